// File: rtl/tpiu_pkg.sv
// TPIU shared definitions: sync patterns and inserter state encoding.
// The sync detector uses the same pattern values.
package tpiu_pkg;

    localparam logic [31:0] TPIU_SYNC      = 32'h7FFF_FFFF;
    localparam logic [31:0] TPIU_HALF_SYNC = 32'h7FFF_7FFF;

    typedef logic [0:0] tpiu_state_t;

    localparam tpiu_state_t ST_SYNC = 1'b0;
    localparam tpiu_state_t ST_DATA = 1'b1;

    function automatic logic is_sync_pattern(input logic [31:0] w);
        return (w == TPIU_SYNC) || (w == TPIU_HALF_SYNC);
    endfunction

endpackage

// File: rtl/tpiu_sync_inserter_if.sv
// Trace-in / TPIU-out stream bundle of the sync inserter.
// slave is the inserter's view, master the surrounding logic.
interface tpiu_sync_inserter_if;

    logic [31:0] IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;
    logic        FORCE_SYNC;
    logic [31:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        SYNC_ACTIVE;
    logic        COLLISION;

    modport slave (
        input  IN_DATA, IN_VALID, FORCE_SYNC, OUT_READY,
        output IN_READY, OUT_DATA, OUT_VALID, SYNC_ACTIVE, COLLISION
    );

    modport master (
        output IN_DATA, IN_VALID, FORCE_SYNC, OUT_READY,
        input  IN_READY, OUT_DATA, OUT_VALID, SYNC_ACTIVE, COLLISION
    );

endinterface

// File: rtl/tpiu_sync_sched.sv
// Sync scheduler: period counter, burst counter and pending-force flag.
// sync_step = a sync word is loaded; data_step = a data word is accepted.
module tpiu_sync_sched #(
    parameter int SYNC_PERIOD = 64,
    parameter int SYNC_BURST  = 2,
    parameter int CNT_W       = 16
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic force_sync,
    input  logic sync_step,
    input  logic data_step,
    output logic sync_due,
    output logic burst_done
);

    logic [CNT_W-1:0] period_cnt;
    logic [3:0]       burst_cnt;
    logic             pending;

    assign sync_due   = pending || (period_cnt == CNT_W'(SYNC_PERIOD));
    assign burst_done = (burst_cnt == 4'(SYNC_BURST - 1));

    // Count burst words and accepted data; a completed burst absorbs any force.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            period_cnt <= '0;
            burst_cnt  <= '0;
            pending    <= 1'b0;
        end else if (sync_step) begin
            if (burst_done) begin
                burst_cnt  <= '0;
                period_cnt <= '0;
                pending    <= 1'b0;
            end else begin
                burst_cnt <= burst_cnt + 4'd1;
                pending   <= pending | force_sync;
            end
        end else begin
            if (data_step)
                period_cnt <= period_cnt + 1'b1;
            if (force_sync)
                pending <= 1'b1;
        end
    end

endmodule

// File: rtl/tpiu_sync_inserter.sv
// TPIU sync inserter: merges trace words into a gapless TPIU stream,
// adding full-sync bursts and half-sync filler.
module tpiu_sync_inserter #(
    parameter int SYNC_PERIOD = 64,
    parameter int SYNC_BURST  = 2,
    parameter int CNT_W       = 16
) (
    input logic ACLK,
    input logic ARESET,
    tpiu_sync_inserter_if.slave bus
);

    import tpiu_pkg::*;

    tpiu_state_t state;
    logic [31:0] out_data_q;
    logic        out_valid_q;
    logic        sync_act_q;
    logic        coll_q;
    logic        slot_free;
    logic        emit_sync;
    logic        accept;
    logic        sync_due;
    logic        burst_done;

    assign slot_free = !out_valid_q || bus.OUT_READY;
    assign emit_sync = (state == ST_SYNC) || sync_due;
    // A due burst takes the slot, so no word is accepted alongside it.
    assign bus.IN_READY = (state == ST_DATA) && !sync_due
                          && slot_free && !ARESET;
    assign accept = bus.IN_VALID && bus.IN_READY;

    assign bus.OUT_DATA    = out_data_q;
    assign bus.OUT_VALID   = out_valid_q;
    assign bus.SYNC_ACTIVE = sync_act_q;
    assign bus.COLLISION   = coll_q;

    tpiu_sync_sched #(
        .SYNC_PERIOD(SYNC_PERIOD),
        .SYNC_BURST (SYNC_BURST),
        .CNT_W      (CNT_W)
    ) u_sched (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .force_sync(bus.FORCE_SYNC),
        .sync_step (slot_free && emit_sync),
        .data_step (accept),
        .sync_due  (sync_due),
        .burst_done(burst_done)
    );

    // SYNC/DATA state: leave SYNC once the last burst word is loaded.
    always_ff @(posedge ACLK) begin
        if (ARESET)
            state <= ST_SYNC;
        else if (slot_free && emit_sync)
            state <= burst_done ? ST_DATA : ST_SYNC;
    end

    // Output register: sync word, accepted data or half-sync filler.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sync_act_q  <= 1'b0;
        end else if (slot_free) begin
            out_valid_q <= 1'b1;
            if (emit_sync) begin
                out_data_q <= TPIU_SYNC;
                sync_act_q <= 1'b1;
            end else if (accept) begin
                out_data_q <= bus.IN_DATA;
                sync_act_q <= 1'b0;
            end else begin
                out_data_q <= TPIU_HALF_SYNC;
                sync_act_q <= 1'b0;
            end
        end
    end

    // Flag forwarded trace words that look like sync patterns.
    always_ff @(posedge ACLK) begin
        if (ARESET)
            coll_q <= 1'b0;
        else
            coll_q <= accept && is_sync_pattern(bus.IN_DATA);
    end

endmodule

// File: tb/tb_tpiu_sync_inserter.sv
// Directed bench for tpiu_sync_inserter (SYNC_PERIOD=64, SYNC_BURST=2).
module tb_tpiu_sync_inserter;

    import tpiu_pkg::*;

    logic ACLK;
    logic ARESET;
    tpiu_sync_inserter_if bus();

    tpiu_sync_inserter #(
        .SYNC_PERIOD(64),
        .SYNC_BURST (2),
        .CNT_W      (16)
    ) dut (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .bus   (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int          n_err = 0;
    int          n_chk = 0;
    logic [31:0] got[$];
    logic        gsa[$];
    int          wnum = 0;
    bit          streaming = 0;
    int          stalls = 0;
    logic [31:0] stall_word = '0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Sample at negedge, let the edge happen, then advance the stream.
    task automatic tick();
        bit acc;
        @(negedge ACLK);
        acc = bus.IN_VALID && bus.IN_READY;
        if (bus.IN_VALID && !bus.IN_READY && bus.IN_DATA == stall_word)
            stalls++;
        if (bus.OUT_VALID && bus.OUT_READY) begin
            got.push_back(bus.OUT_DATA);
            gsa.push_back(bus.SYNC_ACTIVE);
        end
        @(posedge ACLK);
        #1;
        if (acc && streaming) begin
            wnum++;
            bus.IN_DATA = 32'(wnum);
        end
    endtask

    task automatic run_until_got(input int n);
        int b = 0;
        while (got.size() < n && b < 2000) begin
            tick();
            b++;
        end
        check("got_tmo", 32'(got.size() >= n), 32'd1);
    endtask

    task automatic run_until_w(input int w);
        int b = 0;
        while (wnum < w && b < 2000) begin
            tick();
            b++;
        end
        check("word_tmo", 32'(wnum >= w), 32'd1);
    endtask

    task automatic do_reset();
        bus.IN_VALID   = 1'b0;
        bus.FORCE_SYNC = 1'b0;
        bus.OUT_READY  = 1'b1;
        streaming      = 0;
        ARESET         = 1'b1;
        tick();
        ARESET = 1'b0;
        repeat (4) tick();
        got.delete();
        gsa.delete();
    endtask

    task automatic start_stream(input int first);
        wnum         = first;
        bus.IN_DATA  = 32'(first);
        bus.IN_VALID = 1'b1;
        streaming    = 1;
        tick();
        got.delete();
        gsa.delete();
    endtask

    // Data words numbered from 1 with 2-word bursts at s0 and s1.
    function automatic logic [31:0] exp_word(input int i, input int s0,
                                             input int s1);
        int d = 0;
        if (i >= s0 && i < s0 + 2) return TPIU_SYNC;
        if (i >= s1 && i < s1 + 2) return TPIU_SYNC;
        if (i >= s0 + 2) d += 2;
        if (i >= s1 + 2) d += 2;
        return 32'(i + 1 - d);
    endfunction

    task automatic check_seq(input string tag, input int n, input int s0,
                             input int s1);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= got.size()) bad++;
            else if (got[i] !== exp_word(i, s0, s1)) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        ARESET         = 1'b1;
        bus.IN_DATA    = '0;
        bus.IN_VALID   = 1'b0;
        bus.FORCE_SYNC = 1'b0;
        bus.OUT_READY  = 1'b1;

        // Reset state and initial burst
        tick();
        tick();
        check("rst_valid", 32'(bus.OUT_VALID), 32'd0);
        check("rst_data", bus.OUT_DATA, 32'd0);
        check("rst_sa", 32'(bus.SYNC_ACTIVE), 32'd0);
        check("rst_coll", 32'(bus.COLLISION), 32'd0);
        check("rst_inrdy", 32'(bus.IN_READY), 32'd0);
        ARESET = 1'b0;
        got.delete();
        gsa.delete();
        tick();
        check("b1_inrdy", 32'(bus.IN_READY), 32'd0);
        check("b1_data", bus.OUT_DATA, TPIU_SYNC);
        tick();
        check("b2_inrdy", 32'(bus.IN_READY), 32'd1);
        repeat (4) tick();
        check("init_w0", got[0], TPIU_SYNC);
        check("init_w1", got[1], TPIU_SYNC);
        check("init_sa0", 32'(gsa[0]), 32'd1);
        check("init_w2", got[2], TPIU_HALF_SYNC);
        check("init_sa2", 32'(gsa[2]), 32'd0);

        // Periodic burst after 64 words
        stall_word = 32'd65;
        stalls     = 0;
        start_stream(1);
        run_until_got(130);
        check("per_w63", got[63], 32'd64);
        check("per_w64", got[64], TPIU_SYNC);
        check("per_w65", got[65], TPIU_SYNC);
        check("per_sa64", 32'(gsa[64]), 32'd1);
        check("per_sa63", 32'(gsa[63]), 32'd0);
        check("per_w66", got[66], 32'd65);
        check("per_w129", got[129], 32'd128);
        check_seq("per_seq", 130, 64, 1000);
        check("per_stalls", 32'(stalls), 32'd2);

        // Forced burst after word 10
        do_reset();
        start_stream(1);
        run_until_w(10);
        bus.FORCE_SYNC = 1'b1;
        tick();
        bus.FORCE_SYNC = 1'b0;
        run_until_got(79);
        check("frc_w9", got[9], 32'd10);
        check("frc_w10", got[10], TPIU_SYNC);
        check("frc_w12", got[12], 32'd11);
        check("frc_w75", got[75], 32'd74);
        check("frc_w76", got[76], TPIU_SYNC);
        check("frc_w78", got[78], 32'd75);
        check_seq("frc_seq", 79, 10, 76);

        // Backpressure in the middle of a burst
        do_reset();
        start_stream(1);
        run_until_w(65);
        tick();
        check("bp_first", bus.OUT_DATA, TPIU_SYNC);
        bus.OUT_READY = 1'b0;
        tick();
        check("bp_hold1", bus.OUT_DATA, TPIU_SYNC);
        check("bp_sa1", 32'(bus.SYNC_ACTIVE), 32'd1);
        tick();
        check("bp_hold2", bus.OUT_DATA, TPIU_SYNC);
        check("bp_valid", 32'(bus.OUT_VALID), 32'd1);
        check("bp_inrdy", 32'(bus.IN_READY), 32'd0);
        bus.OUT_READY = 1'b1;
        run_until_got(70);
        check_seq("bp_seq", 70, 64, 1000);

        // Collisions are flagged and forwarded unchanged
        do_reset();
        check("col_idle", 32'(bus.COLLISION), 32'd0);
        bus.IN_DATA  = TPIU_HALF_SYNC;
        bus.IN_VALID = 1'b1;
        tick();
        check("col_half", 32'(bus.COLLISION), 32'd1);
        check("col_half_d", bus.OUT_DATA, TPIU_HALF_SYNC);
        check("col_half_sa", 32'(bus.SYNC_ACTIVE), 32'd0);
        bus.IN_DATA = 32'h1234_5678;
        tick();
        check("col_clr", 32'(bus.COLLISION), 32'd0);
        check("col_clr_d", bus.OUT_DATA, 32'h1234_5678);
        bus.IN_DATA = TPIU_SYNC;
        tick();
        check("col_full", 32'(bus.COLLISION), 32'd1);
        check("col_full_d", bus.OUT_DATA, TPIU_SYNC);
        check("col_full_sa", 32'(bus.SYNC_ACTIVE), 32'd0);
        bus.IN_VALID = 1'b0;
        tick();
        check("col_end", 32'(bus.COLLISION), 32'd0);
        check("col_fill", bus.OUT_DATA, TPIU_HALF_SYNC);

        // Reset in the middle of a stream
        do_reset();
        start_stream(1);
        run_until_w(6);
        ARESET = 1'b1;
        tick();
        check("mr_valid", 32'(bus.OUT_VALID), 32'd0);
        ARESET = 1'b0;
        got.delete();
        gsa.delete();
        run_until_got(4);
        check("mr_w0", got[0], TPIU_SYNC);
        check("mr_w1", got[1], TPIU_SYNC);
        check("mr_w2", got[2], 32'd6);
        check("mr_w3", got[3], 32'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
